packet_tx_arbiter: RTL and testbench

- Shares the single 16-byte outgoing packet buffer and its packet transmitter between two requesters:
  - the key-exchange sequencer (port prefix kx_);
  - the voice packetizer (port prefix vc_).
- Grants the buffer to one requester at a time and forwards that requester's byte writes to the buffer.
- Launches transmission on the owner's send request, waits for transmitter completion, then releases the buffer.
- Sits between the protocol FSMs and the outgoing packet buffer / transmitter.

---
 rtl/packet_tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_packet_tx_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_tx_arbiter.sv
// packet_tx_arbiter
//   Shares the single 16-byte outgoing packet buffer and its transmitter
//   between the key-exchange sequencer (kx_*) and the voice packetizer (vc_*).
//   One requester owns the buffer at a time. Its byte writes are forwarded to
//   the buffer. Its send request launches the transmitter. The grant is
//   released on transmitter completion, when the owner drops its request, or
//   when the owner holds the grant too long without sending.
//
// Ports
//   clock, reset              system clock, asynchronous active-high reset
//   kx_request / vc_request   level: requester wants the buffer
//   *_write_index/data/enable byte write into the buffer (owner only)
//   *_send                    one-cycle pulse: packet complete, transmit it
//   *_grant                   requester owns the buffer
//   *_done                    one-cycle pulse: packet transmitted, grant gone
//   *_abort                   one-cycle pulse: grant revoked by hold timeout
//   buf_write_index/data/enable  registered write port to the packet buffer
//   tx_start                  one-cycle pulse to the transmitter
//   tx_done                   one-cycle pulse from the transmitter
//   owner                     0 = kx, 1 = vc; valid while either grant is high
module packet_tx_arbiter #(
    parameter int ROUND_ROBIN  = 1,
    parameter int HOLD_TIMEOUT = 64,
    parameter int TO_W         = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       kx_request,
    input  logic [3:0] kx_write_index,
    input  logic [7:0] kx_write_data,
    input  logic       kx_write_enable,
    input  logic       kx_send,
    output logic       kx_grant,
    output logic       kx_done,
    output logic       kx_abort,
    input  logic       vc_request,
    input  logic [3:0] vc_write_index,
    input  logic [7:0] vc_write_data,
    input  logic       vc_write_enable,
    input  logic       vc_send,
    output logic       vc_grant,
    output logic       vc_done,
    output logic       vc_abort,
    output logic [3:0] buf_write_index,
    output logic [7:0] buf_write_data,
    output logic       buf_write_enable,
    output logic       tx_start,
    input  logic       tx_done,
    output logic       owner
);

    typedef enum logic [1:0] {IDLE, OWNED, SEND, WAIT_TX} state_t;

    localparam logic [TO_W-1:0] HOLD_LAST = TO_W'(HOLD_TIMEOUT - 1);

    state_t          state, state_nx;
    logic [TO_W-1:0] hold_cnt, hold_cnt_nx;
    logic            last_owner, last_owner_nx;
    logic            owner_nx, kx_grant_nx, vc_grant_nx;
    logic            kx_done_nx, kx_abort_nx, vc_done_nx, vc_abort_nx;
    logic            tx_start_nx, buf_we_nx;
    logic [3:0]      buf_idx_nx;
    logic [7:0]      buf_data_nx;

    logic            own_request, own_send, own_we;
    logic [3:0]      own_idx;
    logic [7:0]      own_data;
    logic            vc_wins;

    // Inputs of whichever requester currently owns the buffer.
    always_comb begin
        own_request = owner ? vc_request      : kx_request;
        own_send    = owner ? vc_send         : kx_send;
        own_we      = owner ? vc_write_enable : kx_write_enable;
        own_idx     = owner ? vc_write_index  : kx_write_index;
        own_data    = owner ? vc_write_data   : kx_write_data;
    end

    // On a tie, round-robin favours whoever did not own the buffer last.
    always_comb begin
        if (kx_request && vc_request)
            vc_wins = (ROUND_ROBIN != 0) && !last_owner;
        else
            vc_wins = vc_request;
    end

    always_comb begin
        state_nx      = state;
        hold_cnt_nx   = hold_cnt;
        last_owner_nx = last_owner;
        owner_nx      = owner;
        kx_grant_nx   = kx_grant;
        vc_grant_nx   = vc_grant;
        kx_done_nx    = 1'b0;
        kx_abort_nx   = 1'b0;
        vc_done_nx    = 1'b0;
        vc_abort_nx   = 1'b0;
        tx_start_nx   = 1'b0;
        buf_we_nx     = 1'b0;
        buf_idx_nx    = buf_write_index;
        buf_data_nx   = buf_write_data;

        unique case (state)
            IDLE: begin
                if (kx_request || vc_request) begin
                    owner_nx    = vc_wins;
                    kx_grant_nx = !vc_wins;
                    vc_grant_nx = vc_wins;
                    hold_cnt_nx = '0;
                    state_nx    = OWNED;
                end
            end
            OWNED: begin
                // Writes are forwarded only while the grant survives this
                // cycle, so a release or abort never leaves a stray strobe.
                if (own_send || (own_request && hold_cnt != HOLD_LAST)) begin
                    buf_we_nx = own_we;
                    if (own_we) begin
                        buf_idx_nx  = own_idx;
                        buf_data_nx = own_data;
                    end
                end
                if (own_send) begin
                    state_nx = SEND;
                end else if (!own_request) begin
                    kx_grant_nx   = 1'b0;
                    vc_grant_nx   = 1'b0;
                    last_owner_nx = owner;
                    state_nx      = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    kx_abort_nx   = !owner;
                    vc_abort_nx   = owner;
                    kx_grant_nx   = 1'b0;
                    vc_grant_nx   = 1'b0;
                    last_owner_nx = owner;
                    state_nx      = IDLE;
                end else begin
                    hold_cnt_nx = hold_cnt + TO_W'(1);
                end
            end
            SEND: begin
                tx_start_nx = 1'b1;
                state_nx    = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    kx_done_nx    = !owner;
                    vc_done_nx    = owner;
                    kx_grant_nx   = 1'b0;
                    vc_grant_nx   = 1'b0;
                    last_owner_nx = owner;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            hold_cnt         <= '0;
            last_owner       <= 1'b1;
            owner            <= 1'b0;
            kx_grant         <= 1'b0;
            vc_grant         <= 1'b0;
            kx_done          <= 1'b0;
            kx_abort         <= 1'b0;
            vc_done          <= 1'b0;
            vc_abort         <= 1'b0;
            tx_start         <= 1'b0;
            buf_write_enable <= 1'b0;
            buf_write_index  <= '0;
            buf_write_data   <= '0;
        end else begin
            state            <= state_nx;
            hold_cnt         <= hold_cnt_nx;
            last_owner       <= last_owner_nx;
            owner            <= owner_nx;
            kx_grant         <= kx_grant_nx;
            vc_grant         <= vc_grant_nx;
            kx_done          <= kx_done_nx;
            kx_abort         <= kx_abort_nx;
            vc_done          <= vc_done_nx;
            vc_abort         <= vc_abort_nx;
            tx_start         <= tx_start_nx;
            buf_write_enable <= buf_we_nx;
            buf_write_index  <= buf_idx_nx;
            buf_write_data   <= buf_data_nx;
        end
    end

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Bench for packet_tx_arbiter: a round-robin and a fixed-priority instance
// share one set of inputs and are each compared every cycle against a
// behavioural model, plus directed sequences for the corner cases.
module tb_packet_tx_arbiter;

    localparam int HT = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic kx_request = 1'b0, kx_write_enable = 1'b0, kx_send = 1'b0;
    logic vc_request = 1'b0, vc_write_enable = 1'b0, vc_send = 1'b0;
    logic [3:0] kx_write_index = '0, vc_write_index = '0;
    logic [7:0] kx_write_data = '0, vc_write_data = '0;
    logic tx_done = 1'b0;

    logic rr_kx_grant, rr_kx_done, rr_kx_abort, rr_vc_grant, rr_vc_done, rr_vc_abort;
    logic rr_buf_we, rr_tx_start, rr_owner;
    logic [3:0] rr_buf_idx;
    logic [7:0] rr_buf_data;
    logic fp_kx_grant, fp_kx_done, fp_kx_abort, fp_vc_grant, fp_vc_done, fp_vc_abort;
    logic fp_buf_we, fp_tx_start, fp_owner;
    logic [3:0] fp_buf_idx;
    logic [7:0] fp_buf_data;

    always #5 clock = ~clock;

    packet_tx_arbiter #(.ROUND_ROBIN(1), .HOLD_TIMEOUT(HT), .TO_W(7)) dut_rr (
        .clock(clock), .reset(reset),
        .kx_request(kx_request), .kx_write_index(kx_write_index), .kx_write_data(kx_write_data),
        .kx_write_enable(kx_write_enable), .kx_send(kx_send),
        .kx_grant(rr_kx_grant), .kx_done(rr_kx_done), .kx_abort(rr_kx_abort),
        .vc_request(vc_request), .vc_write_index(vc_write_index), .vc_write_data(vc_write_data),
        .vc_write_enable(vc_write_enable), .vc_send(vc_send),
        .vc_grant(rr_vc_grant), .vc_done(rr_vc_done), .vc_abort(rr_vc_abort),
        .buf_write_index(rr_buf_idx), .buf_write_data(rr_buf_data), .buf_write_enable(rr_buf_we),
        .tx_start(rr_tx_start), .tx_done(tx_done), .owner(rr_owner)
    );

    packet_tx_arbiter #(.ROUND_ROBIN(0), .HOLD_TIMEOUT(HT), .TO_W(7)) dut_fp (
        .clock(clock), .reset(reset),
        .kx_request(kx_request), .kx_write_index(kx_write_index), .kx_write_data(kx_write_data),
        .kx_write_enable(kx_write_enable), .kx_send(kx_send),
        .kx_grant(fp_kx_grant), .kx_done(fp_kx_done), .kx_abort(fp_kx_abort),
        .vc_request(vc_request), .vc_write_index(vc_write_index), .vc_write_data(vc_write_data),
        .vc_write_enable(vc_write_enable), .vc_send(vc_send),
        .vc_grant(fp_vc_grant), .vc_done(fp_vc_done), .vc_abort(fp_vc_abort),
        .buf_write_index(fp_buf_idx), .buf_write_data(fp_buf_data), .buf_write_enable(fp_buf_we),
        .tx_start(fp_tx_start), .tx_done(tx_done), .owner(fp_owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // holder: -1 nobody, 0 kx, 1 vc. age counts fill cycles since the grant.
    typedef struct {
        int holder;
        int age;
        bit launch_due;
        bit awaiting;
        int prev;
        bit own;
        bit bwe;
        bit [3:0] bi;
        bit [7:0] bd;
        bit start;
        bit kd, ka, vd, va;
    } mdl_t;

    mdl_t m_rr, m_fp;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.holder = -1; m.age = 0; m.launch_due = 0; m.awaiting = 0; m.prev = 1;
        m.own = 0; m.bwe = 0; m.bi = '0; m.bd = '0; m.start = 0;
        m.kd = 0; m.ka = 0; m.vd = 0; m.va = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit rr);
        mdl_t n;
        bit req, snd, we;
        bit [3:0] idx;
        bit [7:0] dat;
        int w;
        n = m;
        n.bwe = 0; n.start = 0; n.kd = 0; n.ka = 0; n.vd = 0; n.va = 0;
        if (m.holder < 0) begin
            if (kx_request || vc_request) begin
                if (kx_request && vc_request) w = rr ? 1 - m.prev : 0;
                else w = vc_request ? 1 : 0;
                n.holder = w; n.own = (w == 1); n.age = 1;
            end
        end else if (m.launch_due) begin
            n.start = 1; n.launch_due = 0; n.awaiting = 1;
        end else if (m.awaiting) begin
            if (tx_done) begin
                n.kd = (m.holder == 0); n.vd = (m.holder == 1);
                n.prev = m.holder; n.holder = -1; n.awaiting = 0;
            end
        end else begin
            req = (m.holder == 1) ? vc_request      : kx_request;
            snd = (m.holder == 1) ? vc_send         : kx_send;
            we  = (m.holder == 1) ? vc_write_enable : kx_write_enable;
            idx = (m.holder == 1) ? vc_write_index  : kx_write_index;
            dat = (m.holder == 1) ? vc_write_data   : kx_write_data;
            if (snd || (req && m.age < HT)) begin
                n.bwe = we;
                if (we) begin n.bi = idx; n.bd = dat; end
            end
            if (snd) n.launch_due = 1;
            else if (!req) begin n.prev = m.holder; n.holder = -1; end
            else if (m.age >= HT) begin
                n.ka = (m.holder == 0); n.va = (m.holder == 1);
                n.prev = m.holder; n.holder = -1;
            end else n.age = m.age + 1;
        end
        return n;
    endfunction

    function automatic logic [20:0] pack_obs(logic kg, logic kd, logic ka, logic vg, logic vd,
                                             logic va, logic bwe, logic st, logic own,
                                             logic [3:0] bi, logic [7:0] bd,
                                             bit mask_buf, bit mask_own);
        return {kg, kd, ka, vg, vd, va, bwe, st, mask_own ? 1'b0 : own,
                mask_buf ? 4'h0 : bi, mask_buf ? 8'h00 : bd};
    endfunction

    function automatic logic [20:0] pack_exp(mdl_t m);
        return pack_obs(m.holder == 0, m.kd, m.ka, m.holder == 1, m.vd, m.va, m.bwe, m.start,
                        m.own, m.bi, m.bd, !m.bwe, m.holder < 0);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rr = mdl_reset();
            m_fp = mdl_reset();
        end else begin
            m_rr = mdl_step(m_rr, 1'b1);
            m_fp = mdl_step(m_fp, 1'b0);
        end
    end

    always @(negedge clock) begin
        check("scoreboard rr",
              32'(pack_obs(rr_kx_grant, rr_kx_done, rr_kx_abort, rr_vc_grant, rr_vc_done,
                           rr_vc_abort, rr_buf_we, rr_tx_start, rr_owner, rr_buf_idx,
                           rr_buf_data, !m_rr.bwe, m_rr.holder < 0)),
              32'(pack_exp(m_rr)));
        check("scoreboard fp",
              32'(pack_obs(fp_kx_grant, fp_kx_done, fp_kx_abort, fp_vc_grant, fp_vc_done,
                           fp_vc_abort, fp_buf_we, fp_tx_start, fp_owner, fp_buf_idx,
                           fp_buf_data, !m_fp.bwe, m_fp.holder < 0)),
              32'(pack_exp(m_fp)));
    end

    bit fp_watch   = 0;
    bit fp_vc_seen = 0;
    always @(negedge clock) if (fp_watch && fp_vc_grant) fp_vc_seen = 1;

    // ---------------- helpers ----------------
    function automatic logic sig(int sel);
        case (sel)
            0:       return rr_kx_grant;
            1:       return rr_vc_grant;
            2:       return rr_tx_start;
            3:       return fp_kx_grant;
            4:       return fp_tx_start;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int max, input string name);
        int n = 0;
        while (n < max && sig(sel) !== 1'b1) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, 32'(sig(sel)), 1);
    endtask

    task automatic clear_inputs();
        kx_request = 0; kx_write_enable = 0; kx_send = 0; kx_write_index = '0; kx_write_data = '0;
        vc_request = 0; vc_write_enable = 0; vc_send = 0; vc_write_index = '0; vc_write_data = '0;
        tx_done = 0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1;
        clear_inputs();
        repeat (2) @(negedge clock);
        reset = 0;
    endtask

    typedef struct {
        bit kr, vr;
        bit ek_rr, ev_rr, ek_fp, ev_fp;
    } arb_vec_t;

    arb_vec_t tbl[8];
    bit saw_start;
    int n_cyc;

    initial begin
        m_rr = mdl_reset();
        m_fp = mdl_reset();
        tbl[0] = '{1, 1, 1, 0, 1, 0};
        tbl[1] = '{1, 1, 0, 1, 1, 0};
        tbl[2] = '{0, 1, 0, 1, 0, 1};
        tbl[3] = '{1, 1, 1, 0, 1, 0};
        tbl[4] = '{1, 0, 1, 0, 1, 0};
        tbl[5] = '{1, 1, 0, 1, 1, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 1, 0, 1, 0};

        #1 reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        check("reset outputs rr",
              32'(pack_obs(rr_kx_grant, rr_kx_done, rr_kx_abort, rr_vc_grant, rr_vc_done,
                           rr_vc_abort, rr_buf_we, rr_tx_start, rr_owner, rr_buf_idx,
                           rr_buf_data, 1'b0, 1'b0)), 0);

        // Arbitration table: grant from IDLE, then release by dropping requests.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            kx_request = tbl[i].kr; vc_request = tbl[i].vr;
            @(posedge clock); #1;
            check($sformatf("arb[%0d] rr kx_grant", i), 32'(rr_kx_grant), 32'(tbl[i].ek_rr));
            check($sformatf("arb[%0d] rr vc_grant", i), 32'(rr_vc_grant), 32'(tbl[i].ev_rr));
            check($sformatf("arb[%0d] fp kx_grant", i), 32'(fp_kx_grant), 32'(tbl[i].ek_fp));
            check($sformatf("arb[%0d] fp vc_grant", i), 32'(fp_vc_grant), 32'(tbl[i].ev_fp));
            @(negedge clock);
            kx_request = 0; vc_request = 0;
            @(posedge clock); #1;
            check($sformatf("arb[%0d] released", i), 32'({rr_kx_grant, rr_vc_grant, rr_kx_done}), 0);
        end

        // Single kx packet.
        @(negedge clock); kx_request = 1;
        wait_until(0, 10, "t1 kx grant");
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            kx_write_enable = 1; kx_write_index = 4'(i); kx_write_data = 8'h55;
            @(posedge clock); #1;
            check("t1 buf_we", 32'(rr_buf_we), 1);
            check("t1 buf_idx", 32'(rr_buf_idx), 32'(i));
            check("t1 buf_data", 32'(rr_buf_data), 32'h55);
        end
        @(negedge clock); kx_write_enable = 0; kx_send = 1;
        @(posedge clock); #1;
        check("t1 tx_start early", 32'(rr_tx_start), 0);
        @(negedge clock); kx_send = 0;
        @(posedge clock); #1;
        check("t1 tx_start", 32'(rr_tx_start), 1);
        @(posedge clock); #1;
        check("t1 tx_start single", 32'(rr_tx_start), 0);
        repeat (18) @(posedge clock);
        #1 check("t1 grant held", 32'(rr_kx_grant), 1);
        @(negedge clock); tx_done = 1; kx_request = 0;
        @(posedge clock); #1;
        check("t1 kx_done", 32'(rr_kx_done), 1);
        check("t1 kx_grant low", 32'(rr_kx_grant), 0);
        @(negedge clock); tx_done = 0;
        @(posedge clock); #1;
        check("t1 kx_done pulse", 32'(rr_kx_done), 0);

        // Round-robin contention from reset.
        apply_reset();
        @(negedge clock); kx_request = 1; vc_request = 1;
        @(posedge clock); #1;
        check("t2 kx first", 32'({rr_kx_grant, rr_vc_grant, rr_owner}), 32'b100);
        @(negedge clock); kx_send = 1; vc_send = 1;
        @(negedge clock); kx_send = 0; vc_send = 0;
        wait_until(2, 5, "t2 tx_start kx");
        @(negedge clock); tx_done = 1; kx_request = 0;
        @(negedge clock); tx_done = 0; kx_request = 1;
        @(posedge clock); #1;
        check("t2 vc second", 32'({rr_kx_grant, rr_vc_grant, rr_owner}), 32'b011);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vc_write_enable = 1; vc_write_index = 4'(i + 2); vc_write_data = 8'hAA;
            kx_write_enable = 1; kx_write_index = 4'd9; kx_write_data = 8'h11;
            @(posedge clock); #1;
            check("t2 vc buf_idx", 32'(rr_buf_idx), 32'(i + 2));
            check("t2 vc buf_data", 32'(rr_buf_data), 32'hAA);
        end
        @(negedge clock);
        vc_write_enable = 0; kx_write_enable = 0; vc_send = 1; kx_send = 1;
        @(negedge clock); vc_send = 0; kx_send = 0;
        wait_until(2, 5, "t2 tx_start vc");
        @(negedge clock); tx_done = 1; kx_request = 0; vc_request = 0;
        @(posedge clock); #1;
        check("t2 vc_done", 32'({rr_vc_done, rr_kx_done}), 32'b10);
        @(negedge clock); tx_done = 0;

        // Fixed priority: both requests held over three packets.
        fp_watch = 1; fp_vc_seen = 0;
        @(negedge clock); kx_request = 1; vc_request = 1;
        for (int p = 0; p < 3; p++) begin
            wait_until(3, 5, "t3 fp kx grant");
            @(negedge clock); kx_send = 1; vc_send = 1;
            @(negedge clock); kx_send = 0; vc_send = 0;
            wait_until(4, 5, "t3 fp tx_start");
            @(negedge clock); tx_done = 1;
            @(posedge clock); #1;
            check("t3 fp kx_done", 32'(fp_kx_done), 1);
            @(negedge clock); tx_done = 0;
            if (p == 2) begin kx_request = 0; vc_request = 0; end
        end
        fp_watch = 0;
        check("t3 fp vc never granted", 32'(fp_vc_seen), 0);

        // Hold timeout on vc with kx pending.
        repeat (2) @(negedge clock);
        vc_request = 1;
        @(posedge clock); #1;
        check("t4 vc grant", 32'(rr_vc_grant), 1);
        @(negedge clock); kx_request = 1;
        n_cyc = 0; saw_start = 0;
        while (n_cyc < 100 && rr_vc_abort !== 1'b1) begin
            @(posedge clock); #1;
            n_cyc++;
            if (rr_tx_start) saw_start = 1;
        end
        check("t4 abort delay", 32'(n_cyc), 32'(HT));
        check("t4 vc_grant low", 32'(rr_vc_grant), 0);
        check("t4 fp vc_abort", 32'(fp_vc_abort), 1);
        check("t4 no tx_start", 32'(saw_start), 0);
        @(negedge clock); vc_request = 0;
        @(posedge clock); #1;
        check("t4 kx granted next", 32'({rr_kx_grant, rr_vc_abort}), 32'b10);

        // kx drops request mid-ownership.
        repeat (3) @(negedge clock);
        kx_request = 0;
        @(posedge clock); #1;
        check("t5 release", 32'({rr_kx_grant, rr_kx_done, rr_kx_abort, rr_tx_start}), 0);

        // tx_done while idle is ignored.
        @(negedge clock); tx_done = 1;
        @(posedge clock); #1;
        check("t5 idle tx_done", 32'({rr_kx_done, rr_vc_done, rr_kx_grant, rr_vc_grant}), 0);
        @(negedge clock); tx_done = 0;

        // Write and send in the same cycle.
        @(negedge clock); kx_request = 1;
        wait_until(0, 5, "t5 kx grant");
        @(negedge clock);
        kx_write_enable = 1; kx_write_index = 4'd15; kx_write_data = 8'h3C; kx_send = 1;
        @(posedge clock); #1;
        check("t5 last write", 32'({rr_buf_we, rr_buf_idx, rr_buf_data, rr_tx_start}),
              32'({1'b1, 4'hF, 8'h3C, 1'b0}));
        @(negedge clock); kx_write_enable = 0; kx_send = 0;
        @(posedge clock); #1;
        check("t5 tx_start after write", 32'({rr_tx_start, rr_buf_we}), 32'b10);

        // Async reset in WAIT_TX.
        #2 reset = 1;
        #1;
        check("t6 rr outputs in reset",
              32'(pack_obs(rr_kx_grant, rr_kx_done, rr_kx_abort, rr_vc_grant, rr_vc_done,
                           rr_vc_abort, rr_buf_we, rr_tx_start, rr_owner, rr_buf_idx,
                           rr_buf_data, 1'b0, 1'b0)), 0);
        check("t6 fp grant in reset", 32'({fp_kx_grant, fp_tx_start}), 0);
        @(negedge clock); kx_request = 0;
        @(negedge clock); reset = 0;
        @(negedge clock); kx_request = 1;
        @(posedge clock); #1;
        check("t6 kx regrant", 32'(rr_kx_grant), 1);
        @(negedge clock); kx_request = 0;

        // Random traffic against the model; a quiet-send window provokes timeouts.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if ($urandom_range(0, 15) == 0) kx_request = ~kx_request;
            if ($urandom_range(0, 15) == 0) vc_request = ~vc_request;
            kx_write_enable = 1'($urandom_range(0, 1));
            kx_write_index  = 4'($urandom);
            kx_write_data   = 8'($urandom);
            vc_write_enable = 1'($urandom_range(0, 1));
            vc_write_index  = 4'($urandom);
            vc_write_data   = 8'($urandom);
            if (c >= 1500 && c < 2200) begin
                kx_send = 0; vc_send = 0;
            end else begin
                kx_send = ($urandom_range(0, 19) == 0);
                vc_send = ($urandom_range(0, 19) == 0);
            end
            tx_done = ($urandom_range(0, 7) == 0);
        end
        @(negedge clock);
        clear_inputs();
        repeat (4) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
